cpu_run_ctrl: RTL and testbench

Synthesizable run controller that drives the MIPS pipeline core through one or more back-to-back test runs. It sequences the core's reset, counts cycles and retired instructions, detects end-of-program as a tight self-loop, and flags a watchdog timeout. It sits between the simulation top and `mips`, replacing hand-written reset/stimulus delays with a parametrised, self-checking sequence.

---
 rtl/cpu_run_ctrl.sv | 156 +++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: sequences reset and test runs of the pipeline core,
// counts cycles/retires, detects self-loop halt and watchdog timeout.
module cpu_run_ctrl #(
    parameter int CNT_W       = 32,
    parameter int RST_CYCLES  = 4,
    parameter int TIMEOUT     = 100000,
    parameter int LOOP_THRESH = 8,
    parameter int NUM_RUNS    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             retire_valid,
    input  logic [31:0]      retire_pc,
    output logic             cpu_reset,
    output logic             running,
    output logic             done,
    output logic             timeout,
    output logic [7:0]       run_idx,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retire_count
);

    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int SW = $clog2(LOOP_THRESH + 1);

    localparam logic [RW-1:0]    RST_LAST  = RW'(RST_CYCLES - 1);
    localparam logic [SW-1:0]    SAME_HALT = SW'(LOOP_THRESH);
    localparam logic [CNT_W-1:0] WD_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [7:0]       LAST_RUN  = 8'(NUM_RUNS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_HOLD,
        S_RUN,
        S_DONE,
        S_FAIL
    } state_t;

    state_t         state;
    logic [RW-1:0]  rst_cnt;
    logic [31:0]    last_pc;
    logic           trk_valid;
    logic [SW-1:0]  same_cnt;

    logic [SW-1:0]  same_nxt;
    logic           idle_like;
    logic           start_ok;
    logic           halt;
    logic           last_run;
    logic           wd_hit;
    logic           enter_hold;

    // Loop tracker look-ahead, halt/watchdog decisions and hold entry
    always_comb begin
        same_nxt = SW'(1);
        if (trk_valid && (retire_pc == last_pc)) begin
            same_nxt = same_cnt + SW'(1);
        end
        idle_like = (state == S_IDLE) || (state == S_DONE) ||
                    (state == S_FAIL);
        start_ok  = start && idle_like;
        halt      = (state == S_RUN) && retire_valid &&
                    (same_nxt == SAME_HALT);
        last_run  = (run_idx == LAST_RUN);
        wd_hit    = (state == S_RUN) && !halt &&
                    (cycle_count == WD_LAST);
        enter_hold = start_ok || (halt && !last_run);
    end

    // Run sequencer: state, flags, counters and loop tracker
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            cpu_reset    <= 1'b1;
            running      <= 1'b0;
            done         <= 1'b0;
            timeout      <= 1'b0;
            run_idx      <= '0;
            cycle_count  <= '0;
            retire_count <= '0;
            rst_cnt      <= '0;
            last_pc      <= '0;
            trk_valid    <= 1'b0;
            same_cnt     <= '0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE, S_FAIL: begin
                    cpu_reset <= 1'b1;
                    running   <= 1'b0;
                    if (start) begin
                        state   <= S_RST_HOLD;
                        run_idx <= '0;
                        done    <= 1'b0;
                        timeout <= 1'b0;
                    end
                end
                S_RST_HOLD: begin
                    cpu_reset <= 1'b1;
                    running   <= 1'b0;
                    if (rst_cnt == RST_LAST) begin
                        state     <= S_RUN;
                        cpu_reset <= 1'b0;
                        running   <= 1'b1;
                    end else begin
                        rst_cnt <= rst_cnt + RW'(1);
                    end
                end
                S_RUN: begin
                    if (retire_valid) begin
                        last_pc   <= retire_pc;
                        trk_valid <= 1'b1;
                        same_cnt  <= same_nxt;
                        if (retire_count != CNT_MAX) begin
                            retire_count <= retire_count + CNT_W'(1);
                        end
                    end
                    if (halt) begin
                        running   <= 1'b0;
                        cpu_reset <= 1'b1;
                        if (last_run) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= S_RST_HOLD;
                            run_idx <= run_idx + 8'd1;
                        end
                    end else if (wd_hit) begin
                        state     <= S_FAIL;
                        timeout   <= 1'b1;
                        running   <= 1'b0;
                        cpu_reset <= 1'b1;
                    end else if (cycle_count != CNT_MAX) begin
                        cycle_count <= cycle_count + CNT_W'(1);
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    cpu_reset <= 1'b1;
                    running   <= 1'b0;
                end
            endcase
            // Every run starts from cleared counters and an empty tracker
            if (enter_hold) begin
                rst_cnt      <= '0;
                cycle_count  <= '0;
                retire_count <= '0;
                last_pc      <= '0;
                trk_valid    <= 1'b0;
                same_cnt     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: directed runs on three configurations; expected
// run-boundary snapshots are queued and checked by a negedge monitor.
module tb_cpu_run_ctrl;

    localparam int EV_NONE  = 0;
    localparam int EV_RESET = 1;
    localparam int EV_RISE  = 2;
    localparam int EV_FALL  = 3;

    typedef struct {
        int          id;
        int          dut;
        int          kind;
        logic        cr;
        logic        dn;
        logic        to;
        logic [7:0]  idx;
        logic [31:0] cyc;
        logic [31:0] ret;
        int          aux;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn [3];
    logic        st   [3];
    logic        rv   [3];
    logic [31:0] pc   [3];
    logic        cr_o   [3];
    logic        run_o  [3];
    logic        done_o [3];
    logic        to_o   [3];
    logic [7:0]  idx_o  [3];
    logic [31:0] cyc_o  [3];
    logic [31:0] ret_o  [3];

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   gap    [3] = '{0, 0, 0};
    int   runlen [3] = '{0, 0, 0};
    logic prev_rst [3] = '{1'b1, 1'b1, 1'b1};
    logic prev_run [3] = '{1'b0, 1'b0, 1'b0};

    always #5 clk = ~clk;

    cpu_run_ctrl u0 (
        .clk(clk), .reset(rstn[0]), .start(st[0]),
        .retire_valid(rv[0]), .retire_pc(pc[0]),
        .cpu_reset(cr_o[0]), .running(run_o[0]),
        .done(done_o[0]), .timeout(to_o[0]), .run_idx(idx_o[0]),
        .cycle_count(cyc_o[0]), .retire_count(ret_o[0])
    );

    cpu_run_ctrl #(.TIMEOUT(50)) u1 (
        .clk(clk), .reset(rstn[1]), .start(st[1]),
        .retire_valid(rv[1]), .retire_pc(pc[1]),
        .cpu_reset(cr_o[1]), .running(run_o[1]),
        .done(done_o[1]), .timeout(to_o[1]), .run_idx(idx_o[1]),
        .cycle_count(cyc_o[1]), .retire_count(ret_o[1])
    );

    cpu_run_ctrl #(.NUM_RUNS(3)) u2 (
        .clk(clk), .reset(rstn[2]), .start(st[2]),
        .retire_valid(rv[2]), .retire_pc(pc[2]),
        .cpu_reset(cr_o[2]), .running(run_o[2]),
        .done(done_o[2]), .timeout(to_o[2]), .run_idx(idx_o[2]),
        .cycle_count(cyc_o[2]), .retire_count(ret_o[2])
    );

    function automatic exp_t mk(input int id, input int d, input int kind,
                                input logic cr, input logic dn,
                                input logic to, input logic [7:0] idx,
                                input logic [31:0] cyc,
                                input logic [31:0] ret, input int aux);
        exp_t e;
        e.id = id; e.dut = d; e.kind = kind; e.cr = cr; e.dn = dn;
        e.to = to; e.idx = idx; e.cyc = cyc; e.ret = ret; e.aux = aux;
        return e;
    endfunction

    task automatic chk(input string nm, input int id,
                       input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s (t%0d): got 0x%0h, expected 0x%0h",
                     nm, id, act, want);
        end
    endtask

    task automatic judge(input int k, input int ev);
        exp_t e;
        if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event dut%0d: got kind %0d, expected none",
                     k, ev);
        end else begin
            e = q.pop_front();
            chk("dut", e.id, k, e.dut);
            chk("event_kind", e.id, ev, e.kind);
            chk("cpu_reset", e.id, {31'd0, cr_o[k]}, {31'd0, e.cr});
            chk("done", e.id, {31'd0, done_o[k]}, {31'd0, e.dn});
            chk("timeout", e.id, {31'd0, to_o[k]}, {31'd0, e.to});
            chk("run_idx", e.id, {24'd0, idx_o[k]}, {24'd0, e.idx});
            chk("cycle_count", e.id, cyc_o[k], e.cyc);
            chk("retire_count", e.id, ret_o[k], e.ret);
            if (ev == EV_RISE) chk("reset_hold_len", e.id, gap[k], e.aux);
            if (ev == EV_FALL) chk("run_len", e.id, runlen[k], e.aux);
        end
    endtask

    // Monitor: detect reset entry and run start/end per DUT, then judge
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            int ev;
            ev = EV_NONE;
            if (!rstn[k] && prev_rst[k]) ev = EV_RESET;
            else if (rstn[k] && prev_run[k] && !run_o[k]) ev = EV_FALL;
            else if (rstn[k] && !prev_run[k] && run_o[k]) ev = EV_RISE;
            if (run_o[k]) runlen[k] = (ev == EV_RISE) ? 1 : runlen[k] + 1;
            if (ev != EV_NONE) judge(k, ev);
            if (ev == EV_FALL) gap[k] = 1;
            else if (st[k]) gap[k] = 0;
            else if (!run_o[k] && cr_o[k]) gap[k] = gap[k] + 1;
            prev_rst[k] = rstn[k];
            prev_run[k] = run_o[k];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int k);
        st[k] = 1'b1;
        step();
        st[k] = 1'b0;
    endtask

    task automatic retire(input int k, input logic [31:0] a);
        rv[k] = 1'b1;
        pc[k] = a;
        step();
        rv[k] = 1'b0;
    endtask

    task automatic wait_run(input int k, input logic want);
        int n;
        n = 0;
        while (run_o[k] !== want && n < 200) begin
            step();
            n++;
        end
        if (run_o[k] !== want) begin
            checks++;
            failures++;
            $display("FAIL wait_running dut%0d: got %0b, expected %0b",
                     k, run_o[k], want);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            rstn[k] = 1'b0; st[k] = 1'b0; rv[k] = 1'b0; pc[k] = '0;
            q.push_back(mk(0, k, EV_RESET, 1, 0, 0, 0, 0, 0, 0));
        end
        step();
        step();
        for (int k = 0; k < 3; k++) rstn[k] = 1'b1;
        step();

        // t1: defaults, 3 straight-line retires then 8x self-loop
        q.push_back(mk(1, 0, EV_RISE, 0, 0, 0, 0, 0, 0, 4));
        q.push_back(mk(1, 0, EV_FALL, 1, 1, 0, 0, 10, 11, 11));
        pulse_start(0);
        wait_run(0, 1'b1);
        retire(0, 32'h3000);
        retire(0, 32'h3004);
        retire(0, 32'h3008);
        repeat (8) retire(0, 32'h300c);
        repeat (2) step();

        // t2: restart from DONE, start ignored in RUN, reset mid-run
        q.push_back(mk(2, 0, EV_RISE, 0, 0, 0, 0, 0, 0, 4));
        q.push_back(mk(2, 0, EV_RESET, 1, 0, 0, 0, 0, 0, 0));
        pulse_start(0);
        wait_run(0, 1'b1);
        retire(0, 32'h100);
        st[0] = 1'b1;
        retire(0, 32'h104);
        st[0] = 1'b0;
        retire(0, 32'h108);
        retire(0, 32'h10c);
        retire(0, 32'h110);
        rstn[0] = 1'b0;
        repeat (2) step();
        rstn[0] = 1'b1;
        repeat (2) step();

        // t3: interrupted loop plus an idle cycle inside the streak
        q.push_back(mk(3, 0, EV_RISE, 0, 0, 0, 0, 0, 0, 4));
        q.push_back(mk(3, 0, EV_FALL, 1, 1, 0, 0, 16, 16, 17));
        pulse_start(0);
        wait_run(0, 1'b1);
        repeat (7) retire(0, 32'h3010);
        retire(0, 32'h3014);
        repeat (3) retire(0, 32'h3010);
        step();
        repeat (5) retire(0, 32'h3010);
        repeat (2) step();

        // t4: TIMEOUT=50 with no retires
        q.push_back(mk(4, 1, EV_RISE, 0, 0, 0, 0, 0, 0, 4));
        q.push_back(mk(4, 1, EV_FALL, 1, 0, 1, 0, 49, 0, 50));
        pulse_start(1);
        wait_run(1, 1'b1);
        wait_run(1, 1'b0);
        repeat (2) step();

        // t5: restart from FAIL, halt on the last watchdog cycle
        q.push_back(mk(5, 1, EV_RISE, 0, 0, 0, 0, 0, 0, 4));
        q.push_back(mk(5, 1, EV_FALL, 1, 1, 0, 0, 49, 8, 50));
        pulse_start(1);
        wait_run(1, 1'b1);
        repeat (42) step();
        repeat (8) retire(1, 32'h4000);
        repeat (2) step();

        // t6: NUM_RUNS=3 back-to-back
        for (int r = 0; r < 3; r++) begin
            q.push_back(mk(6, 2, EV_RISE, 0, 0, 0, 8'(r), 0, 0, 4));
            if (r < 2)
                q.push_back(mk(6, 2, EV_FALL, 1, 0, 0, 8'(r + 1), 0, 0, 9));
            else
                q.push_back(mk(6, 2, EV_FALL, 1, 1, 0, 8'd2, 8, 9, 9));
        end
        pulse_start(2);
        for (int r = 0; r < 3; r++) begin
            wait_run(2, 1'b1);
            retire(2, 32'h2000);
            repeat (8) retire(2, 32'h2004);
        end
        repeat (3) step();

        for (int n = 0; n < 20 && q.size() != 0; n++) step();
        chk("queue_drain", 7, q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
